// File: rtl/riscv_v_pkg.sv
// Shared types for the vector permutation unit: opcode, FSM state and fixed latencies.
package riscv_v_pkg;

  typedef enum logic [1:0] {
    PERM_MV_X_S     = 2'd0,
    PERM_MV_S_X     = 2'd1,
    PERM_SLIDEUP    = 2'd2,
    PERM_SLIDEDOWN  = 2'd3
  } riscv_v_perm_op_e;

  localparam int unsigned RISCV_V_PERM_MV_LATENCY = 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } riscv_v_perm_state_e;

endpackage

// File: rtl/riscv_v_permutation_unit_if.sv
// Request/response bundle between operand read, the permutation unit and writeback.
interface riscv_v_permutation_unit_if
  import riscv_v_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned EW        = 32,
  parameter int unsigned NUM_ELEMS = 8
);
  localparam int unsigned IW = $clog2(NUM_ELEMS) + 1;

  logic                    in_valid;
  logic                    in_ready;
  riscv_v_perm_op_e        op;
  logic [XLEN-1:0]         offset;
  logic [IW-1:0]           vl;
  logic [XLEN-1:0]         scalar_in;
  logic [NUM_ELEMS*EW-1:0] vec_src;
  logic [NUM_ELEMS*EW-1:0] vec_old;
  logic                    out_valid;
  logic                    out_ready;
  logic [NUM_ELEMS*EW-1:0] vec_out;
  logic [XLEN-1:0]         scalar_out;

  modport master (
    output in_valid, op, offset, vl, scalar_in, vec_src, vec_old, out_ready,
    input  in_ready, out_valid, vec_out, scalar_out
  );

  modport slave (
    input  in_valid, op, offset, vl, scalar_in, vec_src, vec_old, out_ready,
    output in_ready, out_valid, vec_out, scalar_out
  );

endinterface

// File: rtl/riscv_v_perm_chunk_sel.sv
// Slide element selection for one CHUNK-wide slice of the register group.
module riscv_v_perm_chunk_sel
  import riscv_v_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned EW        = 32,
  parameter int unsigned NUM_ELEMS = 8,
  parameter int unsigned CHUNK     = 2,
  parameter int unsigned CW        = 2
) (
  input  logic [CW-1:0]               chunk_idx,
  input  riscv_v_perm_op_e            op,
  input  logic [XLEN-1:0]             offset,
  input  logic [$clog2(NUM_ELEMS):0]  vl,
  input  logic [NUM_ELEMS*EW-1:0]     src,
  input  logic [NUM_ELEMS*EW-1:0]     old,
  output logic [CHUNK*EW-1:0]         chunk_out
);
  localparam int unsigned LW = $clog2(NUM_ELEMS);

  logic [EW-1:0] src_e [NUM_ELEMS];
  logic [EW-1:0] old_e [NUM_ELEMS];

  for (genvar g = 0; g < NUM_ELEMS; g++) begin : g_unpack
    assign src_e[g] = src[g*EW +: EW];
    assign old_e[g] = old[g*EW +: EW];
  end

  // One extra bit so pos+offset cannot wrap for offsets near 2^XLEN.
  logic [XLEN:0]  off_w, vl_w, ne_w, pos, dn_src;
  logic [LW-1:0]  idx, up_src;

  assign off_w = {1'b0, offset};
  assign vl_w  = (XLEN+1)'(vl);
  assign ne_w  = (XLEN+1)'(NUM_ELEMS);

  always_comb begin
    chunk_out = '0;
    idx       = '0;
    pos       = '0;
    up_src    = '0;
    dn_src    = '0;
    for (int unsigned j = 0; j < CHUNK; j++) begin
      idx    = LW'(32'(chunk_idx) * CHUNK + j);
      pos    = (XLEN+1)'(idx);
      up_src = LW'(pos - off_w);
      dn_src = pos + off_w;
      chunk_out[j*EW +: EW] = old_e[idx];
      if (pos < vl_w) begin
        unique case (op)
          PERM_SLIDEUP:   if (pos >= off_w) chunk_out[j*EW +: EW] = src_e[up_src];
          PERM_SLIDEDOWN: chunk_out[j*EW +: EW] = (dn_src < ne_w) ? src_e[dn_src[LW-1:0]] : '0;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/riscv_v_permutation_unit.sv
// Multi-cycle vector permutation engine: vmv.x.s, vmv.s.x, vslideup, vslidedown.
module riscv_v_permutation_unit
  import riscv_v_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned EW        = 32,
  parameter int unsigned NUM_ELEMS = 8,
  parameter int unsigned CHUNK     = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  riscv_v_permutation_unit_if.slave   bus
);
  localparam int unsigned NCHUNK = NUM_ELEMS / CHUNK;
  localparam int unsigned IW     = $clog2(NUM_ELEMS) + 1;
  localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned NW     = NUM_ELEMS * EW;

  riscv_v_perm_state_e state, state_n;
  riscv_v_perm_op_e    op_q;
  logic [CW-1:0]       cnt;
  logic [XLEN-1:0]     off_q, scal_q, x_from_elem;
  logic [IW-1:0]       vl_q, vl_c;
  logic [NW-1:0]       src_q, old_q, vec_q;
  logic [EW-1:0]       elem_from_x;
  logic [CHUNK*EW-1:0] chunk_res;
  logic                accept, is_mv;

  assign accept = (state == IDLE) && bus.in_valid;
  assign is_mv  = (bus.op == PERM_MV_X_S) || (bus.op == PERM_MV_S_X);
  assign vl_c   = (bus.vl > IW'(NUM_ELEMS)) ? IW'(NUM_ELEMS) : bus.vl;

  if (EW < XLEN) begin : g_x_sext
    assign x_from_elem = {{(XLEN-EW){bus.vec_src[EW-1]}}, bus.vec_src[EW-1:0]};
  end else begin : g_x_trunc
    assign x_from_elem = bus.vec_src[XLEN-1:0];
  end

  if (EW > XLEN) begin : g_e_sext
    assign elem_from_x = {{(EW-XLEN){bus.scalar_in[XLEN-1]}}, bus.scalar_in};
  end else begin : g_e_trunc
    assign elem_from_x = bus.scalar_in[EW-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (bus.in_valid) state_n = is_mv ? DONE : BUSY;
      BUSY:    if (cnt == CW'(NCHUNK - 1)) state_n = DONE;
      DONE:    if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign bus.vec_out    = vec_q;
  assign bus.scalar_out = scal_q;

  riscv_v_perm_chunk_sel #(
    .XLEN      (XLEN),
    .EW        (EW),
    .NUM_ELEMS (NUM_ELEMS),
    .CHUNK     (CHUNK),
    .CW        (CW)
  ) u_chunk_sel (
    .chunk_idx (cnt),
    .op        (op_q),
    .offset    (off_q),
    .vl        (vl_q),
    .src       (src_q),
    .old       (old_q),
    .chunk_out (chunk_res)
  );

  // MV results are formed at the accept edge; slides start from vec_old and
  // overwrite one chunk per BUSY cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= PERM_MV_X_S;
      off_q  <= '0;
      vl_q   <= '0;
      src_q  <= '0;
      old_q  <= '0;
      vec_q  <= '0;
      scal_q <= '0;
      cnt    <= '0;
    end else begin
      unique case (state)
        IDLE: if (accept) begin
          op_q   <= bus.op;
          off_q  <= bus.offset;
          vl_q   <= vl_c;
          src_q  <= bus.vec_src;
          old_q  <= bus.vec_old;
          cnt    <= '0;
          vec_q  <= bus.vec_old;
          scal_q <= '0;
          if (bus.op == PERM_MV_X_S) scal_q <= x_from_elem;
          if (bus.op == PERM_MV_S_X && vl_c != '0) vec_q[EW-1:0] <= elem_from_x;
        end
        BUSY: begin
          for (int unsigned k = 0; k < NCHUNK; k++) begin
            if (cnt == CW'(k)) vec_q[k*CHUNK*EW +: CHUNK*EW] <= chunk_res;
          end
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  vl_legal: assert property (@(posedge clk) disable iff (!rst_n)
    accept |-> (bus.vl <= IW'(NUM_ELEMS)))
    else $error("vl exceeds NUM_ELEMS");

endmodule

// File: tb/tb_riscv_v_permutation_unit.sv
// Directed and random bench for riscv_v_permutation_unit across CHUNK = 2, 1 and 8.
module tb_riscv_v_permutation_unit;
  import riscv_v_pkg::*;

  localparam logic [63:0] SRC = 64'h1716_1514_1312_1110;
  localparam logic [63:0] OLD = 64'hA7A6_A5A4_A3A2_A1A0;
  localparam int SLIDE_LAT = 8 / 2 + 1;

  typedef struct {
    logic [63:0] vec;
    logic [31:0] scal;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             sweep = 1'b0;
  logic             out_ready = 1'b0;
  riscv_v_perm_op_e op = PERM_MV_X_S;
  logic [31:0]      offset = '0;
  logic [31:0]      scalar_in = '0;
  logic [3:0]       vl = '0;
  logic [63:0]      src = '0;
  logic [63:0]      old = '0;

  int   checks = 0;
  int   failures = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  riscv_v_permutation_unit_if #(.XLEN(32), .EW(8), .NUM_ELEMS(8)) bus_m ();
  riscv_v_permutation_unit_if #(.XLEN(32), .EW(8), .NUM_ELEMS(8)) bus_1 ();
  riscv_v_permutation_unit_if #(.XLEN(32), .EW(8), .NUM_ELEMS(8)) bus_8 ();

  assign bus_m.in_valid = in_valid;
  assign bus_1.in_valid = in_valid && sweep;
  assign bus_8.in_valid = in_valid && sweep;
  assign bus_m.op = op;             assign bus_1.op = op;             assign bus_8.op = op;
  assign bus_m.offset = offset;     assign bus_1.offset = offset;     assign bus_8.offset = offset;
  assign bus_m.vl = vl;             assign bus_1.vl = vl;             assign bus_8.vl = vl;
  assign bus_m.scalar_in = scalar_in; assign bus_1.scalar_in = scalar_in; assign bus_8.scalar_in = scalar_in;
  assign bus_m.vec_src = src;       assign bus_1.vec_src = src;       assign bus_8.vec_src = src;
  assign bus_m.vec_old = old;       assign bus_1.vec_old = old;       assign bus_8.vec_old = old;
  assign bus_m.out_ready = out_ready; assign bus_1.out_ready = out_ready; assign bus_8.out_ready = out_ready;

  riscv_v_permutation_unit #(.XLEN(32), .EW(8), .NUM_ELEMS(8), .CHUNK(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus_m));
  riscv_v_permutation_unit #(.XLEN(32), .EW(8), .NUM_ELEMS(8), .CHUNK(1)) u_dut_c1 (
    .clk(clk), .rst_n(rst_n), .bus(bus_1));
  riscv_v_permutation_unit #(.XLEN(32), .EW(8), .NUM_ELEMS(8), .CHUNK(8)) u_dut_c8 (
    .clk(clk), .rst_n(rst_n), .bus(bus_8));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_vec(riscv_v_perm_op_e o, logic [31:0] off, logic [3:0] v,
                                            logic [31:0] sc, logic [63:0] s, logic [63:0] ol);
    logic [63:0]     r;
    longint unsigned k;
    longint unsigned o64;
    r   = ol;
    o64 = {32'b0, off};
    for (int i = 0; i < 8; i++) begin
      if (i < int'(v)) begin
        case (o)
          PERM_SLIDEUP: if (64'(i) >= o64) begin
            k = 64'(i) - o64;
            r[i*8 +: 8] = s[int'(k)*8 +: 8];
          end
          PERM_SLIDEDOWN: begin
            k = 64'(i) + o64;
            r[i*8 +: 8] = (k < 64'd8) ? s[int'(k)*8 +: 8] : 8'h00;
          end
          PERM_MV_S_X: if (i == 0) r[7:0] = sc[7:0];
          default: ;
        endcase
      end
    end
    return r;
  endfunction

  task automatic send(input riscv_v_perm_op_e o, input logic [31:0] off, input logic [3:0] v,
                      input logic [31:0] sc, input logic [63:0] s, input logic [63:0] ol,
                      input bit sw, input logic [63:0] ev, input logic [31:0] es);
    @(negedge clk);
    chk("in_ready_pre", 64'(bus_m.in_ready), 64'd1);
    op = o; offset = off; vl = v; scalar_in = sc; src = s; old = ol; sweep = sw;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    op        = riscv_v_perm_op_e'($urandom_range(0, 3));
    offset    = $urandom;
    vl        = 4'($urandom_range(0, 8));
    scalar_in = $urandom;
    src       = {$urandom, $urandom};
    old       = {$urandom, $urandom};
    sbq.push_back('{vec: ev, scal: es});
  endtask

  task automatic recv(input string tag, input bit sw, input int exp_lat, input int hold);
    int   lat = 0;
    bit   done = 1'b0;
    exp_t e;
    for (int c = 1; c <= 40 && !done; c++) begin
      @(negedge clk);
      if (bus_m.out_valid && lat == 0) lat = c;
      done = bus_m.out_valid && (!sw || (bus_1.out_valid && bus_8.out_valid));
    end
    checks++;
    assert (done) else begin
      failures++;
      $error("FAIL %s_timeout observed=out_valid_low expected=out_valid_high", tag);
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    e = sbq.pop_front();
    for (int k = 0; k < hold; k++) begin
      if (k == 0) in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk({tag, "_hold_vec"}, bus_m.vec_out, e.vec);
      chk({tag, "_hold_scal"}, 64'(bus_m.scalar_out), 64'(e.scal));
      chk({tag, "_hold_in_ready"}, 64'(bus_m.in_ready), 64'd0);
      chk({tag, "_hold_out_valid"}, 64'(bus_m.out_valid), 64'd1);
    end
    in_valid = 1'b0;
    chk({tag, "_vec"}, bus_m.vec_out, e.vec);
    chk({tag, "_scal"}, 64'(bus_m.scalar_out), 64'(e.scal));
    if (sw) begin
      chk({tag, "_c1_vec"}, bus_1.vec_out, e.vec);
      chk({tag, "_c1_scal"}, 64'(bus_1.scalar_out), 64'(e.scal));
      chk({tag, "_c8_vec"}, bus_8.vec_out, e.vec);
      chk({tag, "_c8_scal"}, 64'(bus_8.scalar_out), 64'(e.scal));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_post_out_valid"}, 64'(bus_m.out_valid), 64'd0);
    chk({tag, "_post_in_ready"}, 64'(bus_m.in_ready), 64'd1);
    if (hold > 0) begin
      @(negedge clk);
      chk({tag, "_no_extra_accept"}, 64'(bus_m.in_ready), 64'd1);
    end
  endtask

  initial begin
    riscv_v_perm_op_e ro;
    logic [31:0]      roff;
    logic [31:0]      rsc;
    logic [3:0]       rvl;
    logic [63:0]      rsrc;
    logic [63:0]      rold;
    int               rlat;

    #12;
    chk("reset_in_ready", 64'(bus_m.in_ready), 64'd1);
    chk("reset_out_valid", 64'(bus_m.out_valid), 64'd0);
    chk("reset_vec_out", bus_m.vec_out, 64'd0);
    chk("reset_scalar_out", 64'(bus_m.scalar_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    send(PERM_SLIDEUP, 32'd3, 4'd6, 32'd0, SRC, OLD, 1'b1, 64'hA7A6_1211_10A2_A1A0, 32'd0);
    recv("slideup_o3_vl6", 1'b1, SLIDE_LAT, 0);
    send(PERM_SLIDEDOWN, 32'd5, 4'd8, 32'd0, SRC, OLD, 1'b1, 64'h0000_0000_0017_1615, 32'd0);
    recv("slidedown_o5_vl8", 1'b1, SLIDE_LAT, 0);
    send(PERM_SLIDEDOWN, 32'hFFFF_FFFF, 4'd8, 32'd0, SRC, OLD, 1'b1, 64'd0, 32'd0);
    recv("slidedown_omax", 1'b1, SLIDE_LAT, 0);
    send(PERM_SLIDEDOWN, 32'd2, 4'd4, 32'd0, SRC, OLD, 1'b1, 64'hA7A6_A5A4_1514_1312, 32'd0);
    recv("slidedown_o2_vl4", 1'b1, SLIDE_LAT, 0);
    send(PERM_SLIDEUP, 32'd0, 4'd8, 32'd0, SRC, OLD, 1'b1, SRC, 32'd0);
    recv("slideup_o0", 1'b1, SLIDE_LAT, 0);
    send(PERM_SLIDEUP, 32'd8, 4'd8, 32'd0, SRC, OLD, 1'b1, OLD, 32'd0);
    recv("slideup_o8", 1'b1, SLIDE_LAT, 0);
    send(PERM_SLIDEUP, 32'd1, 4'd8, 32'd0, SRC, OLD, 1'b1, 64'h1615_1413_1211_10A0, 32'd0);
    recv("slideup_o1", 1'b1, SLIDE_LAT, 0);
    send(PERM_SLIDEDOWN, 32'd1, 4'd0, 32'd0, SRC, OLD, 1'b1, OLD, 32'd0);
    recv("slidedown_vl0", 1'b1, SLIDE_LAT, 0);
    send(PERM_MV_X_S, 32'd9, 4'd0, 32'd0, 64'h1716_1514_1312_1180, OLD, 1'b1, OLD, 32'hFFFF_FF80);
    recv("mv_x_s_neg", 1'b1, RISCV_V_PERM_MV_LATENCY, 0);
    send(PERM_MV_X_S, 32'd0, 4'd8, 32'd0, 64'h1716_1514_1312_117F, OLD, 1'b1, OLD, 32'h0000_007F);
    recv("mv_x_s_pos", 1'b1, RISCV_V_PERM_MV_LATENCY, 0);
    send(PERM_MV_S_X, 32'd0, 4'd0, 32'h55, SRC, OLD, 1'b1, OLD, 32'd0);
    recv("mv_s_x_vl0", 1'b1, RISCV_V_PERM_MV_LATENCY, 0);
    send(PERM_MV_S_X, 32'd4, 4'd3, 32'h1234_5655, SRC, OLD, 1'b1, 64'hA7A6_A5A4_A3A2_A155, 32'd0);
    recv("mv_s_x_vl3", 1'b1, RISCV_V_PERM_MV_LATENCY, 0);

    send(PERM_SLIDEDOWN, 32'd5, 4'd8, 32'd0, SRC, OLD, 1'b0, 64'h0000_0000_0017_1615, 32'd0);
    recv("backpressure", 1'b0, SLIDE_LAT, 10);

    send(PERM_SLIDEUP, 32'd3, 4'd6, 32'd0, SRC, OLD, 1'b0, 64'd0, 32'd0);
    void'(sbq.pop_back());
    @(negedge clk);
    chk("rst_mid_busy_in_ready", 64'(bus_m.in_ready), 64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 64'(bus_m.out_valid), 64'd0);
    chk("rst_mid_in_ready", 64'(bus_m.in_ready), 64'd1);
    chk("rst_mid_vec_out", bus_m.vec_out, 64'd0);
    chk("rst_mid_scalar_out", 64'(bus_m.scalar_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rst_nothing_emitted", 64'(bus_m.out_valid), 64'd0);
    end
    send(PERM_SLIDEUP, 32'd3, 4'd6, 32'd0, SRC, OLD, 1'b1, 64'hA7A6_1211_10A2_A1A0, 32'd0);
    recv("after_reset", 1'b1, SLIDE_LAT, 0);

    for (int n = 0; n < 24; n++) begin
      ro = riscv_v_perm_op_e'($urandom_range(0, 3));
      case (n % 6)
        0:       roff = 32'd0;
        1:       roff = 32'd1;
        2:       roff = 32'd7;
        3:       roff = 32'd8;
        4:       roff = 32'h8000_0000 | $urandom;
        default: roff = $urandom_range(2, 6);
      endcase
      case ((n + n / 6) % 4)
        0:       rvl = 4'd0;
        1:       rvl = 4'd1;
        2:       rvl = 4'd8;
        default: rvl = 4'($urandom_range(2, 7));
      endcase
      rsrc = {$urandom, $urandom};
      rold = {$urandom, $urandom};
      rsc  = $urandom;
      rlat = (ro == PERM_MV_X_S || ro == PERM_MV_S_X) ? RISCV_V_PERM_MV_LATENCY : SLIDE_LAT;
      send(ro, roff, rvl, rsc, rsrc, rold, 1'b1,
           model_vec(ro, roff, rvl, rsc, rsrc, rold),
           (ro == PERM_MV_X_S) ? {{24{rsrc[7]}}, rsrc[7:0]} : 32'd0);
      recv($sformatf("rnd%0d", n), 1'b1, rlat, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
